// File: rtl/bgp_level_monitor_if.sv
// Wishbone slave bus bundle for the bandgap level monitor.
interface bgp_level_monitor_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/bgp_level_monitor.sv
// Bandgap level monitor: synchronizes and debounces the macro's level output, measures
// high-time and rising edges over a programmable window, exposes results over Wishbone.
module bgp_level_monitor #(
    parameter logic [31:0] ADDR_BASE  = 32'h3000_0000,
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned CNT_W      = 24
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_ni,
    input  logic               bgp_level_i,
    bgp_level_monitor_if.slave wbs,
    output logic               irq_o
);
    localparam int unsigned     DebW   = $clog2(DEB_CYCLES + 1);
    localparam int unsigned     EdgeW  = (CNT_W < 24) ? CNT_W : 24;
    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    typedef enum logic [1:0] {StIdle, StRun, StLatch} state_e;

    state_e            state_q, state_d;
    logic              sync1_q, sync2_q, filt_q, filt_flip, filt_rise;
    logic [DebW-1:0]   deb_cnt_q;
    logic              ack_q, hit, wr, wr_ctrl, wr_win, wr_stat, clr;
    logic [31:0]       dat_q, rd_data, win_wr32;
    logic [1:0]        offs;
    logic              en_q, irq_en_q, done_q, ovf_q, irq_q;
    logic [CNT_W-1:0]  win_q, win_len_q, win_cnt_q, live_high_q, live_edge_q, high_q, edge_q;
    logic              load_win, do_count, do_latch, ovf_set;
    logic [23:0]       edge_rd;
    logic              unused_adr;

    assign unused_adr = ^wbs.wbs_adr_i[1:0];

    // Filter flips after DEB_CYCLES consecutive samples that disagree with it
    assign filt_flip = (sync2_q != filt_q) && (deb_cnt_q == DebW'(DEB_CYCLES - 1));
    assign filt_rise = filt_flip && sync2_q;

    // Two-flop synchronizer followed by the debounce counter
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            filt_q    <= 1'b0;
            deb_cnt_q <= '0;
        end else begin
            sync1_q <= bgp_level_i;
            sync2_q <= sync1_q;
            if (sync2_q == filt_q) begin
                deb_cnt_q <= '0;
            end else if (filt_flip) begin
                deb_cnt_q <= '0;
                filt_q    <= sync2_q;
            end else begin
                deb_cnt_q <= deb_cnt_q + DebW'(1);
            end
        end
    end

    // Bus decode; the ack itself blocks a second hit so acks never come back to back
    assign hit     = wbs.wbs_stb_i & wbs.wbs_cyc_i & ~ack_q
                     & (wbs.wbs_adr_i[31:4] == ADDR_BASE[31:4]);
    assign offs    = wbs.wbs_adr_i[3:2];
    assign wr      = hit & wbs.wbs_we_i;
    assign wr_ctrl = wr & (offs == 2'd0) & wbs.wbs_sel_i[0];
    assign wr_win  = wr & (offs == 2'd1);
    assign wr_stat = wr & (offs == 2'd2) & wbs.wbs_sel_i[0];
    assign clr     = wr_ctrl & wbs.wbs_dat_i[1];

    // Byte-lane merge of a WINDOW write into its current value
    always_comb begin
        win_wr32 = 32'(win_q);
        for (int b = 0; b < 4; b++) begin
            if (wbs.wbs_sel_i[b]) win_wr32[8*b +: 8] = wbs.wbs_dat_i[8*b +: 8];
        end
    end

    // Read-back mux
    always_comb begin
        edge_rd = '0;
        edge_rd[EdgeW-1:0] = edge_q[EdgeW-1:0];
        rd_data = '0;
        unique case (offs)
            2'd0: rd_data = {edge_rd, 5'b0, irq_en_q, 1'b0, en_q};
            2'd1: rd_data = 32'(win_q);
            2'd2: rd_data = {29'b0, ovf_q, filt_q, done_q};
            2'd3: rd_data = 32'(high_q);
        endcase
    end

    // Measurement FSM state register
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) state_q <= StIdle;
        else            state_q <= state_d;
    end

    // Measurement FSM next state; CLR overrides everything, including LATCH
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (en_q && (win_q != '0)) state_d = StRun;
            StRun: begin
                if (!en_q)                                state_d = StIdle;
                else if (win_cnt_q == win_len_q - CntOne) state_d = StLatch;
            end
            StLatch: state_d = (en_q && (win_q != '0)) ? StRun : StIdle;
            default: state_d = StIdle;
        endcase
        if (clr) state_d = StIdle;
    end

    // Measurement FSM outputs
    always_comb begin
        load_win = (state_q != StRun) && (state_d == StRun);
        do_count = (state_q == StRun) && (state_d != StIdle);
        do_latch = (state_q == StLatch) && !clr;
        ovf_set  = do_count && ((win_cnt_q == CntMax) || (filt_q && (live_high_q == CntMax))
                                || (filt_rise && (live_edge_q == CntMax)));
    end

    // Live window counters, zeroed whenever a window is not in progress
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            win_len_q   <= '0;
            win_cnt_q   <= '0;
            live_high_q <= '0;
            live_edge_q <= '0;
        end else if (clr || load_win || (state_q == StIdle)) begin
            if (load_win) win_len_q <= win_q;
            win_cnt_q   <= '0;
            live_high_q <= '0;
            live_edge_q <= '0;
        end else if (do_count) begin
            if (win_cnt_q != CntMax) win_cnt_q <= win_cnt_q + CntOne;
            if (filt_q && (live_high_q != CntMax)) live_high_q <= live_high_q + CntOne;
            if (filt_rise && (live_edge_q != CntMax)) live_edge_q <= live_edge_q + CntOne;
        end
    end

    // Software registers, latched results and the interrupt
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            en_q     <= 1'b0;
            irq_en_q <= 1'b0;
            win_q    <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            high_q   <= '0;
            edge_q   <= '0;
            irq_q    <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                en_q     <= wbs.wbs_dat_i[0];
                irq_en_q <= wbs.wbs_dat_i[2];
            end
            if (wr_win) win_q <= win_wr32[CNT_W-1:0];
            if (clr) begin
                high_q <= '0;
                edge_q <= '0;
                done_q <= 1'b0;
                ovf_q  <= 1'b0;
            end else begin
                if (do_latch) begin
                    high_q <= live_high_q;
                    edge_q <= live_edge_q;
                end
                if (do_latch)                         done_q <= 1'b1;
                else if (wr_stat && wbs.wbs_dat_i[0]) done_q <= 1'b0;
                if (ovf_set)                          ovf_q  <= 1'b1;
                else if (wr_stat && wbs.wbs_dat_i[2]) ovf_q  <= 1'b0;
            end
            irq_q <= done_q & irq_en_q;
        end
    end

    // Single-cycle ack; data only driven alongside it
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ack_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= hit;
            dat_q <= hit ? rd_data : 32'h0;
        end
    end

    assign wbs.wbs_ack_o = ack_q;
    assign wbs.wbs_dat_o = dat_q;
    assign irq_o         = irq_q;
endmodule

// File: tb/tb_bgp_level_monitor.sv
// Self-checking bench for bgp_level_monitor.
module tb_bgp_level_monitor;
    localparam logic [31:0] Base  = 32'h3000_0000;
    localparam logic [31:0] ACtrl = Base;
    localparam logic [31:0] AWin  = Base + 32'h4;
    localparam logic [31:0] AStat = Base + 32'h8;
    localparam logic [31:0] AHigh = Base + 32'hC;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic level = 1'b0;
    logic irq;
    logic sq_run = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] rd;
    logic [31:0] exp_v;

    bgp_level_monitor_if bus();

    bgp_level_monitor #(
        .ADDR_BASE (Base),
        .DEB_CYCLES(4),
        .CNT_W     (24)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_ni  (rst_n),
        .bgp_level_i(level),
        .wbs        (bus),
        .irq_o      (irq)
    );

    always #5 clk = ~clk;

    // One bus access: drive just after a posedge, hit on the next edge, release after ack.
    task automatic wb_access(input logic we, input logic [31:0] adr, input logic [31:0] wdata,
                             input logic [3:0] sel, input logic want_ack,
                             output logic [31:0] rdata);
        logic acked;
        acked = 1'b0;
        rdata = 32'hx;
        @(posedge clk); #1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_we_i  = we;
        bus.wbs_adr_i = adr;
        bus.wbs_dat_i = wdata;
        bus.wbs_sel_i = sel;
        for (int i = 0; i < 4 && !acked; i++) begin
            @(negedge clk);
            if (bus.wbs_ack_o === 1'b1) begin
                acked = 1'b1;
                rdata = bus.wbs_dat_o;
            end
        end
        @(posedge clk); #1;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        checks++;
        if (acked !== want_ack) begin
            errors++;
            $display("FAIL ack_presence adr=%h: got %0b expected %0b", adr, acked, want_ack);
        end
    endtask

    task automatic poll_done(output logic found);
        logic [31:0] s;
        found = 1'b0;
        for (int i = 0; i < 250 && !found; i++) begin
            wb_access(1'b0, AStat, 32'h0, 4'hf, 1'b1, s);
            if (s[0] === 1'b1) found = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (irq !== 1'b0 || bus.wbs_ack_o !== 1'b0 || bus.wbs_dat_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: irq=%b ack=%b dat=%h expected 0 0 0",
                     irq, bus.wbs_ack_o, bus.wbs_dat_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        // Ack must appear exactly one cycle after the strobe and last one cycle
        @(posedge clk); #1;
        bus.wbs_stb_i = 1'b1; bus.wbs_cyc_i = 1'b1; bus.wbs_we_i = 1'b0;
        bus.wbs_adr_i = ACtrl; bus.wbs_sel_i = 4'hf;
        @(negedge clk);
        checks++;
        if (bus.wbs_ack_o !== 1'b0) begin
            errors++; $display("FAIL ack_early: got %b expected 0", bus.wbs_ack_o);
        end
        @(negedge clk);
        checks++;
        if (bus.wbs_ack_o !== 1'b1) begin
            errors++; $display("FAIL ack_timing: got %b expected 1", bus.wbs_ack_o);
        end
        @(posedge clk); #1;
        bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.wbs_ack_o !== 1'b0) begin
            errors++; $display("FAIL ack_width: got %b expected 0", bus.wbs_ack_o);
        end
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(32'h0);
            wb_access(1'b0, Base + 32'(4 * i), 32'h0, 4'hf, 1'b1, rd);
            exp_v = exp_q.pop_front();
            checks++;
            if (rd !== exp_v) begin
                errors++; $display("FAIL reset_reg%0d: got %h expected %h", i, rd, exp_v);
            end
        end
        // Offset 0x10 is outside the decode and must never ack
        wb_access(1'b0, Base + 32'h10, 32'h0, 4'hf, 1'b0, rd);
    endtask

    task automatic test_held_high();
        wb_access(1'b1, AWin, 32'd100, 4'hf, 1'b1, rd);
        wb_access(1'b1, ACtrl, 32'h5, 4'hf, 1'b1, rd);
        // Window's first counted cycle is now; level rises here
        level = 1'b1;
        exp_q.push_back(32'd94);
        exp_q.push_back(32'h0000_0105);
        exp_q.push_back(32'h3);
        repeat (101) @(posedge clk);
        #1;
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL irq_early: got %b expected 0", irq);
        end
        @(posedge clk); #1;
        checks++;
        if (irq !== 1'b1) begin
            errors++; $display("FAIL irq_after_done: got %b expected 1", irq);
        end
        wb_access(1'b0, AHigh, 32'h0, 4'hf, 1'b1, rd);
        exp_v = exp_q.pop_front(); checks++;
        if (rd !== exp_v) begin errors++; $display("FAIL held_high_cnt: got %h expected %h", rd, exp_v); end
        wb_access(1'b0, ACtrl, 32'h0, 4'hf, 1'b1, rd);
        exp_v = exp_q.pop_front(); checks++;
        if (rd !== exp_v) begin errors++; $display("FAIL held_ctrl_edges: got %h expected %h", rd, exp_v); end
        wb_access(1'b0, AStat, 32'h0, 4'hf, 1'b1, rd);
        exp_v = exp_q.pop_front(); checks++;
        if (rd !== exp_v) begin errors++; $display("FAIL held_status: got %h expected %h", rd, exp_v); end
        wb_access(1'b1, ACtrl, 32'h2, 4'hf, 1'b1, rd);
        level = 1'b0;
        repeat (10) @(posedge clk);
    endtask

    task automatic test_glitch();
        logic found;
        wb_access(1'b1, ACtrl, 32'h1, 4'hf, 1'b1, rd);
        for (int g = 0; g < 8; g++) begin
            level = 1'b1; repeat (3) @(posedge clk); #1;
            level = 1'b0; repeat (9) @(posedge clk); #1;
        end
        poll_done(found);
        checks++;
        if (found !== 1'b1) begin errors++; $display("FAIL glitch_done_timeout: got %b expected 1", found); end
        exp_q.push_back(32'h0); exp_q.push_back(32'h1); exp_q.push_back(32'h1);
        wb_access(1'b0, AHigh, 32'h0, 4'hf, 1'b1, rd);
        exp_v = exp_q.pop_front(); checks++;
        if (rd !== exp_v) begin errors++; $display("FAIL glitch_high: got %h expected %h", rd, exp_v); end
        wb_access(1'b0, ACtrl, 32'h0, 4'hf, 1'b1, rd);
        exp_v = exp_q.pop_front(); checks++;
        if (rd !== exp_v) begin errors++; $display("FAIL glitch_edges: got %h expected %h", rd, exp_v); end
        wb_access(1'b0, AStat, 32'h0, 4'hf, 1'b1, rd);
        exp_v = exp_q.pop_front(); checks++;
        if (rd !== exp_v) begin errors++; $display("FAIL glitch_filtered: got %h expected %h", rd, exp_v); end
        wb_access(1'b1, ACtrl, 32'h2, 4'hf, 1'b1, rd);
    endtask

    task automatic test_en_clear();
        logic found;
        level = 1'b1;
        repeat (10) @(posedge clk);
        wb_access(1'b1, ACtrl, 32'h1, 4'hf, 1'b1, rd);
        poll_done(found);
        checks++;
        if (found !== 1'b1) begin errors++; $display("FAIL en_done_timeout: got %b expected 1", found); end
        exp_q.push_back(32'd100);
        wb_access(1'b0, AHigh, 32'h0, 4'hf, 1'b1, rd);
        exp_v = exp_q.pop_front(); checks++;
        if (rd !== exp_v) begin errors++; $display("FAIL full_window_high: got %h expected %h", rd, exp_v); end
        wb_access(1'b1, AStat, 32'h1, 4'hf, 1'b1, rd);
        repeat (30) @(posedge clk);
        wb_access(1'b1, ACtrl, 32'h0, 4'hf, 1'b1, rd);
        repeat (120) @(posedge clk);
        exp_q.push_back(32'h2); exp_q.push_back(32'd100);
        wb_access(1'b0, AStat, 32'h0, 4'hf, 1'b1, rd);
        exp_v = exp_q.pop_front(); checks++;
        if (rd !== exp_v) begin errors++; $display("FAIL en_abort_status: got %h expected %h", rd, exp_v); end
        wb_access(1'b0, AHigh, 32'h0, 4'hf, 1'b1, rd);
        exp_v = exp_q.pop_front(); checks++;
        if (rd !== exp_v) begin errors++; $display("FAIL en_abort_high: got %h expected %h", rd, exp_v); end
    endtask

    task automatic test_clr_at_latch();
        wb_access(1'b1, ACtrl, 32'h1, 4'hf, 1'b1, rd);
        // Window runs 100 cycles from here; the CLR write lands on the LATCH cycle
        repeat (99) @(posedge clk);
        wb_access(1'b1, ACtrl, 32'h2, 4'hf, 1'b1, rd);
        exp_q.push_back(32'h0); exp_q.push_back(32'h2); exp_q.push_back(32'h0);
        wb_access(1'b0, AHigh, 32'h0, 4'hf, 1'b1, rd);
        exp_v = exp_q.pop_front(); checks++;
        if (rd !== exp_v) begin errors++; $display("FAIL clr_latch_high: got %h expected %h", rd, exp_v); end
        wb_access(1'b0, AStat, 32'h0, 4'hf, 1'b1, rd);
        exp_v = exp_q.pop_front(); checks++;
        if (rd !== exp_v) begin errors++; $display("FAIL clr_latch_status: got %h expected %h", rd, exp_v); end
        wb_access(1'b0, ACtrl, 32'h0, 4'hf, 1'b1, rd);
        exp_v = exp_q.pop_front(); checks++;
        if (rd !== exp_v) begin errors++; $display("FAIL clr_latch_ctrl: got %h expected %h", rd, exp_v); end
    endtask

    task automatic test_back_to_back();
        logic found;
        wb_access(1'b1, AWin, 32'd400, 4'hf, 1'b1, rd);
        sq_run = 1'b1;
        fork
            begin
                while (sq_run) begin
                    level = ~level;
                    repeat (20) @(posedge clk);
                    #1;
                end
            end
        join_none
        repeat (50) @(posedge clk);
        wb_access(1'b1, ACtrl, 32'h1, 4'hf, 1'b1, rd);
        for (int w = 0; w < 3; w++) begin
            poll_done(found);
            checks++;
            if (found !== 1'b1) begin errors++; $display("FAIL sq_done_timeout w%0d: got %b expected 1", w, found); end
            exp_q.push_back(32'd200);
            exp_q.push_back(32'd10);
            wb_access(1'b0, AHigh, 32'h0, 4'hf, 1'b1, rd);
            exp_v = exp_q.pop_front(); checks++;
            if (rd === 32'hx || rd < exp_v - 1 || rd > exp_v + 1) begin
                errors++; $display("FAIL sq_high w%0d: got %0d expected %0d+-1", w, rd, exp_v);
            end
            wb_access(1'b0, ACtrl, 32'h0, 4'hf, 1'b1, rd);
            exp_v = exp_q.pop_front(); checks++;
            if (rd === 32'hx || (rd >> 8) < exp_v - 1 || (rd >> 8) > exp_v + 1) begin
                errors++; $display("FAIL sq_edges w%0d: got %0d expected %0d+-1", w, rd >> 8, exp_v);
            end
            wb_access(1'b1, AStat, 32'h1, 4'hf, 1'b1, rd);
        end
        sq_run = 1'b0;
        wb_access(1'b1, ACtrl, 32'h2, 4'hf, 1'b1, rd);
        repeat (25) @(posedge clk);
        level = 1'b0;
        repeat (10) @(posedge clk);
    endtask

    task automatic test_byte_sel();
        wb_access(1'b1, AWin, 32'h0, 4'hf, 1'b1, rd);
        wb_access(1'b1, AWin, 32'hffff_ffff, 4'b0010, 1'b1, rd);
        wb_access(1'b1, AWin, 32'hffff_ffff, 4'b1000, 1'b1, rd);
        exp_q.push_back(32'h0000_ff00);
        wb_access(1'b0, AWin, 32'h0, 4'hf, 1'b1, rd);
        exp_v = exp_q.pop_front(); checks++;
        if (rd !== exp_v) begin errors++; $display("FAIL byte_sel_window: got %h expected %h", rd, exp_v); end
    endtask

    task automatic test_reset_mid_run();
        wb_access(1'b1, AWin, 32'd100, 4'hf, 1'b1, rd);
        wb_access(1'b1, ACtrl, 32'h5, 4'hf, 1'b1, rd);
        repeat (30) @(posedge clk);
        #1;
        bus.wbs_stb_i = 1'b1; bus.wbs_cyc_i = 1'b1; bus.wbs_we_i = 1'b0;
        bus.wbs_adr_i = AHigh; bus.wbs_sel_i = 4'hf;
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.wbs_ack_o !== 1'b0 || irq !== 1'b0) begin
                errors++; $display("FAIL reset_pending_ack c%0d: ack=%b irq=%b expected 0 0",
                                   i, bus.wbs_ack_o, irq);
            end
        end
        bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(32'h0);
            wb_access(1'b0, Base + 32'(4 * i), 32'h0, 4'hf, 1'b1, rd);
            exp_v = exp_q.pop_front(); checks++;
            if (rd !== exp_v) begin errors++; $display("FAIL midrun_reg%0d: got %h expected %h", i, rd, exp_v); end
        end
        repeat (120) @(posedge clk);
        exp_q.push_back(32'h0);
        wb_access(1'b0, AStat, 32'h0, 4'hf, 1'b1, rd);
        exp_v = exp_q.pop_front(); checks++;
        if (rd !== exp_v) begin errors++; $display("FAIL idle_after_reset: got %h expected %h", rd, exp_v); end
    endtask

    task automatic test_w1c_irq();
        logic seen;
        seen = 1'b0;
        wb_access(1'b1, AWin, 32'd20, 4'hf, 1'b1, rd);
        wb_access(1'b1, ACtrl, 32'h5, 4'hf, 1'b1, rd);
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (irq === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b1) begin errors++; $display("FAIL irq_rise: got %b expected 1", seen); end
        wb_access(1'b1, ACtrl, 32'h4, 4'hf, 1'b1, rd);
        exp_q.push_back(32'h1); exp_q.push_back(32'h0);
        wb_access(1'b0, AStat, 32'h0, 4'hf, 1'b1, rd);
        exp_v = exp_q.pop_front(); checks++;
        if (rd !== exp_v) begin errors++; $display("FAIL done_before_w1c: got %h expected %h", rd, exp_v); end
        wb_access(1'b1, AStat, 32'h1, 4'hf, 1'b1, rd);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_drop: got %b expected 0", irq); end
        wb_access(1'b0, AStat, 32'h0, 4'hf, 1'b1, rd);
        exp_v = exp_q.pop_front(); checks++;
        if (rd !== exp_v) begin errors++; $display("FAIL done_after_w1c: got %h expected %h", rd, exp_v); end
    endtask

    initial begin
        bus.wbs_stb_i = 1'b0;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_sel_i = 4'h0;
        bus.wbs_adr_i = 32'h0;
        bus.wbs_dat_i = 32'h0;
        test_reset();
        test_held_high();
        test_glitch();
        test_en_clear();
        test_clr_at_latch();
        test_back_to_back();
        test_byte_sel();
        test_reset_mid_run();
        test_w1c_irq();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end
endmodule

// File: doc/bgp_level_monitor.md
Name: bgp_level_monitor

Overview:
Digital monitor that consumes the bandgap macro's 1-bit comparator/level output (the net driven onto io_out[16]). It synchronizes and debounces that level, then measures high-time and rising edges over a programmable window. Results are exposed to the management SoC as a Wishbone slave register bank, with a window-done interrupt on user_irq[0]. Sits between the analog macro output and the wrapper's Wishbone/IRQ pins.

Parameters:
ADDR_BASE, 32'h3000_0000, base address; block decodes wbs_adr_i[31:4] == ADDR_BASE[31:4]
DEB_CYCLES, 4, consecutive identical synchronized samples required before the filtered level changes (>=1)
CNT_W, 24, width of the window, high-time and edge counters

Ports:
wb_clk_i  input  1  single clock for all logic
wb_rst_ni  input  1  asynchronous active-low reset
bgp_level_i  input  1  raw, asynchronous level from the bandgap macro
wbs_stb_i  input  1  Wishbone strobe
wbs_cyc_i  input  1  Wishbone cycle
wbs_we_i  input  1  write enable
wbs_sel_i  input  4  byte selects
wbs_adr_i  input  32  address
wbs_dat_i  input  32  write data
wbs_ack_o  output  1  acknowledge
wbs_dat_o  output  32  read data
irq_o  output  1  window-done interrupt level (to user_irq[0])

Behaviour:
- Reset (async assert, sync release via the clock edge): every register 0. wbs_ack_o=0, wbs_dat_o=0, irq_o=0, WINDOW=0, filtered level=0.
- Sync: two-flop synchronizer on bgp_level_i. Debounce: a counter tracks how long the synchronized sample has differed from the filtered level. Filtered level flips after DEB_CYCLES consecutive differing samples. A matching sample clears the counter. Raw-to-filtered latency = 2 + DEB_CYCLES cycles.
- Register map (word offsets):
  - 0x0 CTRL (RW): bit0 EN; bit1 CLR, write-1 self-clearing pulse; bit2 IRQ_EN.
  - 0x4 WINDOW (RW): CNT_W-bit window length in cycles.
  - 0x8 STATUS: bit0 DONE, write-1-to-clear; bit1 filtered level (RO); bit2 OVF, write-1-to-clear.
  - 0xC HIGH_CNT (RO).
  - 0x10 is outside the decode; offsets 0x10-0xF alias nothing.
  - Only bits [3:2] of the offset are used. Unused read bits = 0.
- Writes honour wbs_sel_i per byte.
- Measurement FSM, states IDLE, RUN, LATCH:
  - IDLE: enter RUN when EN=1 and WINDOW!=0. Clear the window counter, live high counter and live edge counter.
  - RUN: each cycle, win_cnt+1. live_high+1 if filtered level=1. live_edge+1 on a filtered rising edge. Counters saturate at all-ones and set OVF. When win_cnt==WINDOW-1, go to LATCH.
  - LATCH (1 cycle): HIGH_CNT<=live_high. Edge count goes to CTRL[31:8] read-back, low CNT_W bits, truncated to 24. Set DONE. Return to RUN if EN=1, otherwise IDLE.
  - EN cleared during RUN: go to IDLE immediately, discard live counts, do not set DONE.
  - CLR pulse: forces IDLE, zeroes live counts, HIGH_CNT, edge count, DONE and OVF. CLR has priority over LATCH in the same cycle.
  - WINDOW written during RUN: takes effect on the next window only, because the value is shadowed on IDLE->RUN and LATCH->RUN.
- irq_o = DONE & IRQ_EN, registered. DONE set and SW clear in the same cycle: set wins.
- Wishbone:
  - An access is hit = stb & cyc & address match & !ack.
  - wbs_ack_o pulses exactly 1 cycle, the cycle after a hit; no back-to-back ack. Accesses to other addresses never ack.
  - wbs_dat_o is valid with ack, 0 otherwise.
  - The write takes effect on the ack cycle.
- Reset asserted mid-window: everything returns to reset values asynchronously. The first window after release starts only when software sets EN.

Test Plan:
- Reset, then read all 4 registers: each returns 32'h0. Each ack lasts exactly one cycle, one cycle after stb.
- WINDOW=100, EN=1, bgp_level_i held 1 from cycle 0 -> after the first window: HIGH_CNT=100-(2+4)=94, edge count=1, DONE=1. With IRQ_EN=1, irq_o=1 one cycle after DONE.
- Square wave, 20 cycles high / 20 low, WINDOW=400 -> every window: HIGH_CNT=200 and edge count=10 (±1 at the boundary). Bench reads back-to-back windows without gaps.
- Glitches of 3 cycles (less than DEB_CYCLES) on a low level -> HIGH_CNT=0 and edge count=0. Filtered level stays 0.
- Clear EN at cycle 50 of a 100-cycle window -> DONE stays 0, HIGH_CNT keeps the previous value. A CLR written in the same cycle as LATCH -> all counts and DONE are 0.
- wb_rst_ni pulled low mid-RUN while a Wishbone read is pending -> ack is not issued and all registers are 0. Writing 1 to STATUS bit0 clears DONE and drops irq_o.
